// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared types and constants for the instruction fetch stage
package arm_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned INSTR_W    = 32;
   localparam int unsigned ADDR_W     = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_e;

   // One prefetch slot: what decode sees as {PC_out, instruction}
   typedef struct packed {
      logic [ADDR_W-1:0]  pc_plus4;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Sequential fetch address; wraps modulo 2^ADDR_W
   function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(WORD_BYTES);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc_plus4, instr} entries with flush
module fetch_fifo
   import arm_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push_i,
   input  fetch_entry_t       push_data_i,
   input  logic               pop_i,
   input  logic               flush_i,
   output fetch_entry_t       head_o,
   output logic [CNT_W-1:0]   count_o,
   output logic               full_o,
   output logic               empty_o
);

   fetch_entry_t       mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               do_pop;

   assign do_pop  = pop_i && !empty_o;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Pointer/count update; flush dominates a same-cycle push or pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are don't-care while empty, so no reset
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage with prefetch FIFO and branch redirect
module if_fetch_unit
   import arm_pkg::*;
#(
   parameter int unsigned       DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_addr,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               valid,
   output logic [ADDR_W-1:0]  PC_out,
   output logic [INSTR_W-1:0] instruction
);

   localparam int unsigned      PTR_W   = $clog2(DEPTH);
   localparam int unsigned      CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]  pc_plus4, req_addr;
   logic               req, push, pop;
   logic               fifo_full, fifo_empty;
   logic [CNT_W-1:0]   count, count_after;
   fetch_entry_t       head, push_data;

   assign pc_plus4           = next_pc(fetch_pc_q);
   assign push_data.pc_plus4 = pc_plus4;
   assign push_data.instr    = imem_rdata;
   // A redirect kills the word arriving in the same cycle
   assign push        = (state_q == ST_WAIT) && imem_rvalid && !branch_taken;
   assign pop         = !fifo_empty && !freeze;
   assign count_after = count + CNT_W'(push) - CNT_W'(pop);

   // Fetch state machine and request issue; branch redirect overrides everything
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req        = 1'b0;
      req_addr   = fetch_pc_q;
      if (branch_taken) begin
         fetch_pc_d = branch_addr;
         unique case (state_q)
            ST_WAIT:    state_d = imem_rvalid ? ST_IDLE : ST_DISCARD;
            ST_DISCARD: state_d = imem_rvalid ? ST_IDLE : ST_DISCARD;
            default:    state_d = ST_IDLE;
         endcase
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (!fifo_full) begin
                  req     = 1'b1;
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  fetch_pc_d = pc_plus4;
                  // Chain the next request only if a slot stays free for it
                  if (count_after < DEPTH_C) begin
                     req      = 1'b1;
                     req_addr = pc_plus4;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_DISCARD: begin
               if (imem_rvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and fetch address registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .flush_i     (branch_taken),
      .head_o      (head),
      .count_o     (count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Request is suppressed while reset is held so the bus sees a quiet interface
   assign imem_req    = req && rst;
   assign imem_addr   = imem_req ? req_addr : '0;
   assign valid       = !fifo_empty;
   assign PC_out      = fifo_empty ? '0 : head.pc_plus4;
   assign instruction = fifo_empty ? '0 : head.instr;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, freeze, branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req0, imem_rvalid0, valid0;
   logic [31:0] imem_addr0, imem_rdata0, pc_out0, instr0;
   logic        imem_req1, imem_rvalid1, valid1;
   logic [31:0] imem_addr1, imem_rdata1, pc_out1, instr1;

   int          n_checks = 0;
   int          n_errors = 0;
   int          lat;
   logic        last_req0, last_req1, pend0, pend1;
   logic [31:0] last_addr0, last_addr1, paddr0, paddr1;
   int          cnt0, cnt1;

   logic        t1_v   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic [31:0] t1_pc  [5] = '{32'd0, 32'd0, 32'd4, 32'd8, 32'd12};
   logic [31:0] t1_in  [5] = '{32'd0, 32'd0, 32'd0, 32'd4, 32'd8};
   logic        t2_v   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [31:0] t2_pc  [5] = '{32'd16, 32'd20, 32'd0, 32'd24, 32'd28};
   logic [31:0] t2_in  [5] = '{32'd12, 32'd16, 32'd0, 32'd20, 32'd24};
   logic        t2_rq  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [31:0] t2_ad  [5] = '{32'd0, 32'd20, 32'd24, 32'd28, 32'd32};

   always #5 clk = ~clk;

   if_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0)) dut0 (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .imem_req(imem_req0), .imem_addr(imem_addr0),
      .imem_rvalid(imem_rvalid0), .imem_rdata(imem_rdata0), .valid(valid0),
      .PC_out(pc_out0), .instruction(instr0)
   );

   if_fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) dut1 (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .imem_req(imem_req1), .imem_addr(imem_addr1),
      .imem_rvalid(imem_rvalid1), .imem_rdata(imem_rdata1), .valid(valid1),
      .PC_out(pc_out1), .instruction(instr1)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock: capture this cycle's request, advance, then drive memory responses
   task automatic step();
      #1;
      last_req0 = imem_req0; last_addr0 = imem_addr0;
      last_req1 = imem_req1; last_addr1 = imem_addr1;
      if (imem_req0) begin pend0 = 1'b1; cnt0 = lat; paddr0 = imem_addr0; end
      if (imem_req1) begin pend1 = 1'b1; cnt1 = lat; paddr1 = imem_addr1; end
      @(posedge clk);
      #1;
      imem_rvalid0 = 1'b0;
      imem_rvalid1 = 1'b0;
      if (pend0) begin
         cnt0--;
         if (cnt0 == 0) begin imem_rvalid0 = 1'b1; imem_rdata0 = paddr0; pend0 = 1'b0; end
      end
      if (pend1) begin
         cnt1--;
         if (cnt1 == 0) begin imem_rvalid1 = 1'b1; imem_rdata1 = paddr1; pend1 = 1'b0; end
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
      imem_rvalid0 = 1'b0; imem_rdata0 = 32'h0; imem_rvalid1 = 1'b0; imem_rdata1 = 32'h0;
      lat = 1; pend0 = 1'b0; pend1 = 1'b0; cnt0 = 0; cnt1 = 0; paddr0 = 32'h0; paddr1 = 32'h0;
      #2;
      check_val("rst_valid", valid0, 32'd0);
      check_val("rst_pc", pc_out0, 32'd0);
      check_val("rst_instr", instr0, 32'd0);
      check_val("rst_req", imem_req0, 32'd0);
      check_val("rst_addr", imem_addr0, 32'd0);
      check_val("rst_req_w", imem_req1, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // back-to-back fetch with 1-cycle memory returning address as data
      for (int i = 0; i < 5; i++) begin
         check_val("b2b_valid", valid0, t1_v[i]);
         check_val("b2b_pc", pc_out0, t1_pc[i]);
         check_val("b2b_instr", instr0, t1_in[i]);
         if (i == 2) begin
            check_val("wrap_valid", valid1, 32'd1);
            check_val("wrap_pc", pc_out1, 32'h0);
            check_val("wrap_instr", instr1, 32'hFFFF_FFFC);
         end
         step();
         check_val("b2b_req", last_req0, 32'd1);
         check_val("b2b_addr", last_addr0, 32'(4 * i));
         if (i == 0) check_val("wrap_addr0", last_addr1, 32'hFFFF_FFFC);
         if (i == 1) check_val("wrap_addr1", last_addr1, 32'h0);
      end

      // freeze: FIFO fills, requests stop, head holds; stray rvalid in IDLE ignored
      freeze = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check_val("frz_valid", valid0, 32'd1);
         check_val("frz_pc", pc_out0, 32'd16);
         check_val("frz_instr", instr0, 32'd12);
         if (i == 2) begin imem_rvalid0 = 1'b1; imem_rdata0 = 32'hDEAD_BEEF; end
         step();
         check_val("frz_req", last_req0, 32'd0);
      end

      // release: drain in order, fetching resumes
      freeze = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_val("drn_valid", valid0, t2_v[i]);
         check_val("drn_pc", pc_out0, t2_pc[i]);
         check_val("drn_instr", instr0, t2_in[i]);
         if (i == 4) lat = 3;
         step();
         check_val("drn_req", last_req0, t2_rq[i]);
         if (t2_rq[i]) check_val("drn_addr", last_addr0, t2_ad[i]);
      end

      // async reset mid-WAIT with a valid head
      freeze = 1'b1;
      check_val("prerst_pc", pc_out0, 32'd32);
      check_val("prerst_instr", instr0, 32'd28);
      #2;
      rst = 1'b0;
      #1;
      check_val("arst_valid", valid0, 32'd0);
      check_val("arst_pc", pc_out0, 32'd0);
      check_val("arst_instr", instr0, 32'd0);
      check_val("arst_req", imem_req0, 32'd0);
      check_val("arst_addr", imem_addr0, 32'd0);
      for (int i = 0; i < 3; i++) step();
      check_val("arst_late_valid", valid0, 32'd0);
      freeze = 1'b0;
      lat = 1;
      rst = 1'b1;
      step();
      check_val("restart_req", last_req0, 32'd1);
      check_val("restart_addr", last_addr0, 32'd0);

      // branch while WAIT on a 3-cycle memory
      check_val("br_pre_valid", valid0, 32'd0);
      lat = 3;
      step();
      check_val("br_pre_addr", last_addr0, 32'd4);
      check_val("br_head_pc", pc_out0, 32'd4);
      branch_taken = 1'b1;
      branch_addr  = 32'h100;
      step();
      branch_taken = 1'b0;
      check_val("br_cyc_req", last_req0, 32'd0);
      for (int i = 0; i < 2; i++) begin
         check_val("disc_valid", valid0, 32'd0);
         step();
         check_val("disc_req", last_req0, 32'd0);
      end
      check_val("br_tgt_valid", valid0, 32'd0);
      step();
      check_val("br_tgt_req", last_req0, 32'd1);
      check_val("br_tgt_addr", last_addr0, 32'h100);
      for (int i = 0; i < 3; i++) begin
         check_val("br_wait_valid", valid0, 32'd0);
         if (i == 2) lat = 1;
         step();
         check_val("br_wait_req", last_req0, (i == 2) ? 32'd1 : 32'd0);
         if (i == 2) check_val("br_next_addr", last_addr0, 32'h104);
      end
      check_val("br_first_valid", valid0, 32'd1);
      check_val("br_first_pc", pc_out0, 32'h104);
      check_val("br_first_instr", instr0, 32'h100);

      // branch coincident with rvalid: word dropped
      branch_taken = 1'b1;
      branch_addr  = 32'h200;
      step();
      branch_taken = 1'b0;
      check_val("brrv_req", last_req0, 32'd0);
      check_val("brrv_valid", valid0, 32'd0);
      step();
      check_val("brrv_tgt_req", last_req0, 32'd1);
      check_val("brrv_tgt_addr", last_addr0, 32'h200);
      check_val("brrv_valid2", valid0, 32'd0);
      step();
      check_val("brrv_next_addr", last_addr0, 32'h204);
      check_val("brrv_out_valid", valid0, 32'd1);
      check_val("brrv_out_pc", pc_out0, 32'h204);
      check_val("brrv_out_instr", instr0, 32'h200);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
